shake_squeeze_ctrl: RTL and testbench
=====================================

# shake_squeeze_ctrl

Sequencer for the SHAKE squeeze phase. After the absorb path reports that the padded final block has been permuted, it hands rate-sized blocks to the output buffer, one per output-buffer write. Between blocks it triggers a Keccak permutation until the requested output length is covered. It sits between the absorb controller, the permutation core and the output buffer's dump FSM, and it owns the remaining-length bookkeeping.

## Interface
- RATE_WORDS, 21, 64-bit words per rate block (21 for SHAKE128, 17 for SHAKE256)
- LEN_W, 16, width of the requested output length in 64-bit words
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a squeeze; sampled only in IDLE
- output_len  in  LEN_W  requested output length in words; latched with start
- absorb_done  in  1  final absorb permutation complete; sampled only in WAIT_ABSORB
- perm_start  out  1  one-cycle pulse to start a Keccak permutation
- perm_done  in  1  permutation complete; sampled only in PERM_WAIT
- output_buffer_available  in  1  output buffer free, driven from the dump FSM
- output_buffer_we  out  1  one-cycle load of the current rate block into the output buffer
- block_words  out  $clog2(RATE_WORDS+1)  valid words in the loaded block; valid with output_buffer_we
- last_output_block  out  1  loaded block is the final one; valid with output_buffer_we
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the squeeze completes

## Operation
- States:
  - IDLE → WAIT_ABSORB → WAIT_BUF → (PERM_START → PERM_WAIT → WAIT_BUF)* → DONE → IDLE.
  - The state enum is 3 bits.
- IDLE:
  - On start with output_len ≠ 0: remaining ← output_len, then go to WAIT_ABSORB.
  - On start with output_len = 0: go directly to DONE. No write and no permutation occur.
- WAIT_ABSORB: on absorb_done, go to WAIT_BUF. The first block needs no permutation.
- WAIT_BUF:
  - While output_buffer_available = 0, hold.
  - When output_buffer_available = 1, assert output_buffer_we in the same cycle (Mealy), with:
    - block_words = min(remaining, RATE_WORDS)
    - last_output_block = (remaining ≤ RATE_WORDS)
  - Register update: remaining ← remaining − block_words.
  - If last, go to DONE; otherwise go to PERM_START.
- PERM_START: perm_start = 1 for exactly one cycle, then go to PERM_WAIT.
- PERM_WAIT: on perm_done, go to WAIT_BUF.
- DONE: done = 1 for one cycle, then go to IDLE.
- Arithmetic:
  - remaining is LEN_W bits wide, unsigned.
  - The subtraction never underflows, because block_words ≤ remaining by construction.
- Ignored inputs:
  - start is ignored in any state other than IDLE.
  - Stray perm_done / absorb_done pulses outside their sampling state are ignored.
- block_words and last_output_block are 0 whenever output_buffer_we = 0.

## Timing
- Reset values:
  - state = IDLE, remaining = 0.
  - All outputs are 0: perm_start, output_buffer_we, block_words, last_output_block, busy, done.
- Reset asserted mid-operation: next cycle is IDLE with all outputs 0. No pending pulse is emitted.
- Latencies:
  - start → busy: 1 cycle.
  - absorb_done → earliest output_buffer_we: 1 cycle.
  - output_buffer_we (not last) → perm_start: 1 cycle.
  - perm_done → earliest output_buffer_we: 1 cycle.
  - Final output_buffer_we → done: 1 cycle.
  - done → ready for a new start: 1 cycle (start is sampled the cycle after done).
- Back-pressure: output_buffer_available low for N cycles stalls WAIT_BUF for N cycles. No write is issued while it is low.
- perm_done asserted in the same cycle as perm_start is not sampled. The PERM_WAIT wait is at least 1 cycle.

## Configuration
- SQUEEZE_ABORT_EN defined:
  - Adds input `abort` (1 bit).
  - When abort is high in any state except IDLE, the next state is IDLE and remaining is cleared. done is not pulsed.
  - No output_buffer_we is issued in the cycle abort is high; abort has priority over the write.
- SQUEEZE_ABORT_EN undefined: no abort port; a squeeze always runs to DONE or rst.

## Structure
- Shared package shake_pkg holds:
  - the squeeze_state_t enum;
  - the RATE_WORDS_128 = 21 and RATE_WORDS_256 = 17 constants;
  - the WORD_W = 64 constant.
- One sub-module, squeeze_len_counter, holds:
  - the remaining register, with load and decrement-by-block_words;
  - the combinational min/last computation.
- The FSM stays in shake_squeeze_ctrl.

## Test plan
- RATE_WORDS=21:
  - start with output_len=21, then absorb_done → one output_buffer_we with block_words=21, last=1; zero perm_start pulses; done 1 cycle later.
  - output_len=50 → writes of 21, 21, 8 with last only on the 8-word write. Exactly 2 perm_start pulses, each followed by its perm_done before the next write.
  - output_len=0 → done 1 cycle after start; no output_buffer_we, no perm_start, no need for absorb_done.
  - output_len=30, output_buffer_available held low 5 cycles in WAIT_BUF → output_buffer_we is delayed exactly 5 cycles. A start pulse during busy is ignored, and remaining is unchanged.
  - rst pulsed during PERM_WAIT of a 50-word squeeze → all outputs 0 next cycle. A fresh output_len=21 squeeze then completes normally.
  - With SQUEEZE_ABORT_EN: abort in WAIT_BUF while available=1 → no write, IDLE next cycle, done stays 0.

Source files
------------

// File: rtl/shake_pkg.sv
// ---------------------------------------------------------------------------
// shake_pkg
// Shared definitions for the SHAKE datapath controllers.
//   squeeze_state_t : 3-bit state encoding of the squeeze sequencer
//   RATE_WORDS_128  : rate in 64-bit words for SHAKE128 (21)
//   RATE_WORDS_256  : rate in 64-bit words for SHAKE256 (17)
//   WORD_W          : lane/word width in bits (64)
// ---------------------------------------------------------------------------
package shake_pkg;

    localparam int WORD_W         = 64;
    localparam int RATE_WORDS_128 = 21;
    localparam int RATE_WORDS_256 = 17;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_ABSORB = 3'd1,
        ST_WAIT_BUF    = 3'd2,
        ST_PERM_START  = 3'd3,
        ST_PERM_WAIT   = 3'd4,
        ST_DONE        = 3'd5
    } squeeze_state_t;

endpackage

// File: rtl/squeeze_len_counter.sv
// ---------------------------------------------------------------------------
// squeeze_len_counter
// Remaining-output-length bookkeeping for the squeeze sequencer.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : zero the remaining count (abort path)
//   load         : load load_value into the remaining count
//   load_value   : requested output length in words
//   dec          : subtract the current block size (one block handed out)
//   block_words  : min(remaining, RATE_WORDS), combinational
//   last_block   : remaining <= RATE_WORDS, combinational
// ---------------------------------------------------------------------------
module squeeze_len_counter #(
    parameter  int RATE_WORDS = 21,
    parameter  int LEN_W      = 16,
    localparam int BW         = $clog2(RATE_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [LEN_W-1:0] load_value,
    input  logic             dec,
    output logic [BW-1:0]    block_words,
    output logic             last_block
);

    localparam logic [LEN_W-1:0] RATE_L = LEN_W'(RATE_WORDS);

    logic [LEN_W-1:0] remaining_reg;

    // When the final block is reached the remaining count is at most
    // RATE_WORDS, so its low BW bits carry the whole value.
    assign last_block  = (remaining_reg <= RATE_L);
    assign block_words = last_block ? remaining_reg[BW-1:0] : BW'(RATE_WORDS);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            remaining_reg <= '0;
        end else if (load) begin
            remaining_reg <= load_value;
        end else if (dec) begin
            // block_words <= remaining_reg by construction: no underflow.
            remaining_reg <= remaining_reg - LEN_W'(block_words);
        end
    end

endmodule

// File: rtl/shake_squeeze_ctrl.sv
// ---------------------------------------------------------------------------
// shake_squeeze_ctrl
// Sequencer for the SHAKE squeeze phase. After the final absorb permutation
// it hands rate-sized blocks to the output buffer, running a Keccak
// permutation between blocks until output_len words are covered.
//
// Optional feature macro: SQUEEZE_ABORT_EN (adds the `abort` input).
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   abort                   : (SQUEEZE_ABORT_EN only) cancel the squeeze
//   start, output_len       : squeeze request and its length in words
//   absorb_done             : final absorb permutation finished
//   perm_start / perm_done  : permutation handshake
//   output_buffer_available : output buffer can take a block
//   output_buffer_we        : load current rate block (Mealy on available)
//   block_words             : valid words in the loaded block
//   last_output_block       : loaded block is the final one
//   busy                    : not idle
//   done                    : one-cycle completion pulse
// ---------------------------------------------------------------------------
module shake_squeeze_ctrl
    import shake_pkg::*;
#(
    parameter int RATE_WORDS = 21,
    parameter int LEN_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst,
`ifdef SQUEEZE_ABORT_EN
    input  logic                              abort,
`endif
    input  logic                              start,
    input  logic [LEN_W-1:0]                  output_len,
    input  logic                              absorb_done,
    output logic                              perm_start,
    input  logic                              perm_done,
    input  logic                              output_buffer_available,
    output logic                              output_buffer_we,
    output logic [$clog2(RATE_WORDS+1)-1:0]   block_words,
    output logic                              last_output_block,
    output logic                              busy,
    output logic                              done
);

    localparam int BW = $clog2(RATE_WORDS + 1);

    squeeze_state_t state_reg, state_next;

    logic          len_load;
    logic          len_clear;
    logic [BW-1:0] blk_words_raw;
    logic          blk_last_raw;
    logic          abort_hit;

`ifdef SQUEEZE_ABORT_EN
    assign abort_hit = abort && (state_reg != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign len_clear = abort_hit;

    squeeze_len_counter #(
        .RATE_WORDS (RATE_WORDS),
        .LEN_W      (LEN_W)
    ) u_len (
        .clk         (clk),
        .rst         (rst),
        .clear       (len_clear),
        .load        (len_load),
        .load_value  (output_len),
        .dec         (output_buffer_we),
        .block_words (blk_words_raw),
        .last_block  (blk_last_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        len_load          = 1'b0;
        perm_start        = 1'b0;
        output_buffer_we  = 1'b0;
        block_words       = '0;
        last_output_block = 1'b0;
        done              = 1'b0;
        busy              = (state_reg != ST_IDLE);

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (output_len != '0) begin
                        len_load   = 1'b1;
                        state_next = ST_WAIT_ABSORB;
                    end else begin
                        // Zero-length request: nothing to emit, report done.
                        state_next = ST_DONE;
                    end
                end
            end
            ST_WAIT_ABSORB: begin
                // The state after the final absorb already holds block 0.
                if (absorb_done) begin
                    state_next = ST_WAIT_BUF;
                end
            end
            ST_WAIT_BUF: begin
                if (output_buffer_available) begin
                    output_buffer_we  = 1'b1;
                    block_words       = blk_words_raw;
                    last_output_block = blk_last_raw;
                    state_next        = blk_last_raw ? ST_DONE : ST_PERM_START;
                end
            end
            ST_PERM_START: begin
                perm_start = 1'b1;
                state_next = ST_PERM_WAIT;
            end
            ST_PERM_WAIT: begin
                if (perm_done) begin
                    state_next = ST_WAIT_BUF;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a write offered this cycle.
        if (abort_hit) begin
            state_next        = ST_IDLE;
            len_load          = 1'b0;
            perm_start        = 1'b0;
            output_buffer_we  = 1'b0;
            block_words       = '0;
            last_output_block = 1'b0;
            done              = 1'b0;
        end
    end

endmodule

// File: tb/tb_shake_squeeze_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shake_squeeze_ctrl
// Directed bench for shake_squeeze_ctrl (RATE_WORDS=21). A queue-based model
// expands each requested length into its list of (words, last) blocks; a
// monitor compares every write against it and checks the idle zeroing of the
// block fields. Directed tasks check the latencies and event counts with
// hand-computed literals.
// ---------------------------------------------------------------------------
module tb_shake_squeeze_ctrl;

    localparam int RATE  = 21;
    localparam int LEN_W = 16;
    localparam int BW    = $clog2(RATE + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] output_len = '0;
    logic             absorb_done = 1'b0;
    logic             perm_done = 1'b0;
    logic             avail = 1'b0;
    logic             perm_start;
    logic             we;
    logic [BW-1:0]    block_words;
    logic             last;
    logic             busy;
    logic             done;
`ifdef SQUEEZE_ABORT_EN
    logic             abort = 1'b0;
`endif

    always #5 clk = ~clk;

    shake_squeeze_ctrl #(.RATE_WORDS(RATE), .LEN_W(LEN_W)) dut (
        .clk                     (clk),
        .rst                     (rst),
`ifdef SQUEEZE_ABORT_EN
        .abort                   (abort),
`endif
        .start                   (start),
        .output_len              (output_len),
        .absorb_done             (absorb_done),
        .perm_start              (perm_start),
        .perm_done               (perm_done),
        .output_buffer_available (avail),
        .output_buffer_we        (we),
        .block_words             (block_words),
        .last_output_block       (last),
        .busy                    (busy),
        .done                    (done)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_we   = 0;
    int n_perm = 0;
    int n_done = 0;

    typedef struct {
        int words;
        bit last;
    } blk_t;

    blk_t exp_q[$];
    int   log_q[$];

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: split a length into rate-sized blocks, last one possibly short.
    task automatic plan(int len);
        int r;
        r = len;
        while (r > 0) begin
            blk_t b;
            b.words = (r > RATE) ? RATE : r;
            b.last  = (r <= RATE);
            exp_q.push_back(b);
            r -= b.words;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, " perm_start"}, int'(perm_start), 0);
        chk({tag, " we"}, int'(we), 0);
        chk({tag, " block_words"}, int'(block_words), 0);
        chk({tag, " last"}, int'(last), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
    endtask

    // Monitor: every write must match the next modelled block.
    always @(negedge clk) begin
        blk_t e;
        if (!rst) begin
            if (we) begin
                n_we++;
                log_q.push_back(int'(block_words));
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("block_words", int'(block_words), e.words);
                    chk("last_block", int'(last), int'(e.last));
                end
                chk("we_with_perm_start", int'(perm_start), 0);
            end else begin
                chk("idle_block_words", int'(block_words), 0);
                chk("idle_last", int'(last), 0);
            end
            if (perm_start) n_perm++;
            if (done) n_done++;
        end
    end

    // kind: 0 normal, 1 reset in first PERM_WAIT, 2 abort in first WAIT_BUF
    task automatic run(string tag, int len, int stall, int kind,
                       int e_we, int e_perm, int e_done);
        int w0, p0, d0, nblk;
        w0 = n_we; p0 = n_perm; d0 = n_done;
        exp_q.delete();
        log_q.delete();
        plan(len);
        nblk = (len + RATE - 1) / RATE;

        tick();
        start = 1'b1; output_len = LEN_W'(len); avail = 1'b1;
        look();
        chk({tag, " busy_before_start"}, int'(busy), 0);
        tick();
        start = 1'b0; output_len = 16'hffff; perm_done = 1'b1;  // stray pulse
        look();
        chk({tag, " busy_latency"}, int'(busy), 1);
        if (len == 0) begin
            chk({tag, " done_zero_len"}, int'(done), 1);
            tick();
            perm_done = 1'b0;
            look();
            chk({tag, " done_one_cycle"}, int'(done), 0);
            chk({tag, " busy_after_done"}, int'(busy), 0);
        end else begin
            chk({tag, " done_early"}, int'(done), 0);
            tick();
            perm_done = 1'b0; absorb_done = 1'b1;
            look();
            chk({tag, " we_before_absorb"}, int'(we), 0);
            tick();
            absorb_done = 1'b0;
            if (stall > 0) begin
                avail = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    if (s > 0) tick();
                    start = (s == 1);            // ignored while busy
                    output_len = 16'd7;
                    look();
                    chk({tag, " we_stalled"}, int'(we), 0);
                end
                tick();
                start = 1'b0; avail = 1'b1;
            end
`ifdef SQUEEZE_ABORT_EN
            if (kind == 2) begin
                abort = 1'b1;
                look();
                chk({tag, " we_on_abort"}, int'(we), 0);
                tick();
                abort = 1'b0;
                look();
                chk({tag, " busy_after_abort"}, int'(busy), 0);
                chk({tag, " done_after_abort"}, int'(done), 0);
                tick();
                look();
                chk({tag, " done_later"}, int'(done), 0);
                exp_q.delete();
                nblk = 0;
            end
`endif
            for (int b = 0; b < nblk; b++) begin
                look();
                chk({tag, " we_latency"}, int'(we), 1);
                if (b == nblk - 1) begin
                    tick();
                    look();
                    chk({tag, " done_pulse"}, int'(done), 1);
                    chk({tag, " busy_in_done"}, int'(busy), 1);
                    tick();
                    look();
                    chk({tag, " done_cleared"}, int'(done), 0);
                    chk({tag, " busy_cleared"}, int'(busy), 0);
                end else begin
                    tick();
                    perm_done = 1'b1;            // same cycle as perm_start
                    look();
                    chk({tag, " perm_start_latency"}, int'(perm_start), 1);
                    chk({tag, " we_in_perm_start"}, int'(we), 0);
                    tick();
                    perm_done = 1'b0;
                    if (kind == 1) begin
                        rst = 1'b1;
                        look();
                        tick();
                        rst = 1'b0;
                        look();
                        chk_zero({tag, " after_rst"});
                        exp_q.delete();
                        break;
                    end
                    look();
                    chk({tag, " perm_start_one_cycle"}, int'(perm_start), 0);
                    chk({tag, " we_in_perm_wait"}, int'(we), 0);
                    tick();
                    perm_done = 1'b1;
                    look();
                    chk({tag, " we_before_perm_done"}, int'(we), 0);
                    tick();
                    perm_done = 1'b0;
                end
            end
        end
        chk({tag, " write_count"}, n_we - w0, e_we);
        chk({tag, " perm_count"}, n_perm - p0, e_perm);
        chk({tag, " done_count"}, n_done - d0, e_done);
        if (kind == 0) chk({tag, " model_drained"}, exp_q.size(), 0);
        $display("run %s len=%0d: writes=%0d perms=%0d dones=%0d", tag, len,
                 n_we - w0, n_perm - p0, n_done - d0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        look();
        chk_zero("reset_held");
        tick();
        rst = 1'b0;
        look();
        chk_zero("reset_released");

        run("len21", 21, 0, 0, 1, 0, 1);
        run("len50", 50, 0, 0, 3, 2, 1);
        chk("len50 block0", (log_q.size() > 0) ? log_q[0] : -1, 21);
        chk("len50 block1", (log_q.size() > 1) ? log_q[1] : -1, 21);
        chk("len50 block2", (log_q.size() > 2) ? log_q[2] : -1, 8);
        run("len0", 0, 0, 0, 0, 0, 1);
        run("len30_stall", 30, 5, 0, 2, 1, 1);
        chk("len30 block1", (log_q.size() > 1) ? log_q[1] : -1, 9);
        run("len42", 42, 0, 0, 2, 1, 1);
        run("len1", 1, 2, 0, 1, 0, 1);
        run("rst_mid", 50, 0, 1, 1, 1, 0);
        run("after_rst", 21, 0, 0, 1, 0, 1);
`ifdef SQUEEZE_ABORT_EN
        run("abort", 21, 0, 2, 0, 0, 0);
        run("after_abort", 22, 0, 0, 2, 1, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
